nora_mst_arbiter: RTL and testbench

Two-requester arbiter for the NORA master bus into the bus controller (the nora_mst_* interface). Requester 0 is the ICD controller; requester 1 is a second bus master, e.g. the SPI-flash boot loader that copies images into SRAM. The block serialises their accesses and keeps the downstream request stable for the whole access. It returns ack and read data to the owning requester only, and it bounds every access with a timeout.

---
 rtl/nora_mst_arbiter.sv | 176 +++++++++++++++++
 tb/tb_nora_mst_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nora_mst_arbiter.sv
// Two-requester arbiter for the NORA master bus. It serialises ICD and secondary-master accesses,
// holds the downstream request stable for each access, and bounds every access with a timeout.
module nora_mst_arbiter #(
  parameter int unsigned TIMEOUT    = 1023,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic [23:0] m0_addr_i,
  input  logic [7:0]  m0_data_i,
  input  logic        m0_req_sram_i,
  input  logic        m0_req_other_i,
  input  logic        m0_rwn_i,
  input  logic        m0_lock_i,
  output logic [7:0]  m0_datard_o,
  output logic        m0_ack_o,
  input  logic [23:0] m1_addr_i,
  input  logic [7:0]  m1_data_i,
  input  logic        m1_req_sram_i,
  input  logic        m1_req_other_i,
  input  logic        m1_rwn_i,
  input  logic        m1_lock_i,
  output logic [7:0]  m1_datard_o,
  output logic        m1_ack_o,
  output logic [23:0] mst_addr_o,
  output logic [7:0]  mst_data_o,
  output logic        mst_req_sram_o,
  output logic        mst_req_other_o,
  output logic        mst_rwn_o,
  input  logic [7:0]  mst_datard_i,
  input  logic        mst_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_err_o,
  input  logic        err_clr_i
);

  localparam logic [1:0]  StIdle      = 2'd0;
  localparam logic [1:0]  StBusy      = 2'd1;
  localparam logic [1:0]  StDone      = 2'd2;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        lock_hold_q, lock_hold_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        req_sram_q, req_sram_d;
  logic        req_other_q, req_other_d;
  logic        rwn_q, rwn_d;
  logic [7:0]  datard0_q, datard0_d;
  logic [7:0]  datard1_q, datard1_d;
  logic [1:0]  ack_q, ack_d;
  logic        err_q, err_d;

  logic act0, act1, locked_act, sel, sel_sram, sel_other, err_set;

  assign act0       = m0_req_sram_i | m0_req_other_i;
  assign act1       = m1_req_sram_i | m1_req_other_i;
  assign locked_act = last_q ? act1 : act0;
  assign sel_sram   = sel ? m1_req_sram_i : m0_req_sram_i;
  assign sel_other  = sel ? m1_req_other_i : m0_req_other_i;

  always_comb begin
    if (lock_hold_q && locked_act) begin
      sel = last_q;
    end else if (act0 && act1) begin
      sel = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      sel = act1;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lock_hold_d = lock_hold_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_sram_d  = req_sram_q;
    req_other_d = req_other_q;
    rwn_d       = rwn_q;
    datard0_d   = datard0_q;
    datard1_d   = datard1_q;
    ack_d       = 2'b00;
    err_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lock_hold_q && !locked_act) lock_hold_d = 1'b0;
        if (act0 || act1) begin
          state_d     = StBusy;
          owner_d     = sel;
          addr_d      = sel ? m1_addr_i : m0_addr_i;
          data_d      = sel ? m1_data_i : m0_data_i;
          rwn_d       = sel ? m1_rwn_i : m0_rwn_i;
          req_sram_d  = sel_sram;
          // req_sram wins if a requester illegally raises both
          req_other_d = sel_other & ~sel_sram;
          cnt_d       = 16'd0;
        end
      end
      StBusy: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (mst_ack_i || cnt_q == TimeoutLast) begin
          state_d     = StDone;
          req_sram_d  = 1'b0;
          req_other_d = 1'b0;
          ack_d       = owner_q ? 2'b10 : 2'b01;
          err_set     = ~mst_ack_i;
          if (owner_q) datard1_d = mst_ack_i ? mst_datard_i : 8'hFF;
          else         datard0_d = mst_ack_i ? mst_datard_i : 8'hFF;
        end
      end
      StDone: begin
        state_d     = StIdle;
        last_d      = owner_q;
        lock_hold_d = owner_q ? m1_lock_i : m0_lock_i;
      end
      default: state_d = StIdle;
    endcase
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      lock_hold_q <= 1'b0;
      cnt_q       <= 16'd0;
      addr_q      <= 24'd0;
      data_q      <= 8'd0;
      req_sram_q  <= 1'b0;
      req_other_q <= 1'b0;
      rwn_q       <= 1'b1;
      datard0_q   <= 8'd0;
      datard1_q   <= 8'd0;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lock_hold_q <= lock_hold_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_sram_q  <= req_sram_d;
      req_other_q <= req_other_d;
      rwn_q       <= rwn_d;
      datard0_q   <= datard0_d;
      datard1_q   <= datard1_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign mst_addr_o      = addr_q;
  assign mst_data_o      = data_q;
  assign mst_req_sram_o  = req_sram_q;
  assign mst_req_other_o = req_other_q;
  assign mst_rwn_o       = rwn_q;
  assign m0_datard_o     = datard0_q;
  assign m1_datard_o     = datard1_q;
  assign m0_ack_o        = ack_q[0];
  assign m1_ack_o        = ack_q[1];
  assign timeout_err_o   = err_q;
  assign grant_o         = (state_q == StBusy || state_q == StDone) ?
                           (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_nora_mst_arbiter.sv
// Directed bench for nora_mst_arbiter: a round-robin instance with TIMEOUT=16 and a fixed-priority
// instance sharing requester stimulus but with its own downstream ack.
module tb_nora_mst_arbiter;

  logic        clk6x = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_data = '0, m1_data = '0;
  logic        m0_sram = 1'b0, m0_other = 1'b0, m0_rwn = 1'b1, m0_lock = 1'b0;
  logic        m1_sram = 1'b0, m1_other = 1'b0, m1_rwn = 1'b1, m1_lock = 1'b0;
  logic [7:0]  mst_datard = '0;
  logic        mst_ack = 1'b0, fp_ack = 1'b0, err_clr = 1'b0;

  logic [7:0]  m0_datard, m1_datard, fp_m0_datard, fp_m1_datard;
  logic        m0_ack, m1_ack, fp_m0_ack, fp_m1_ack;
  logic [23:0] mst_addr, fp_addr;
  logic [7:0]  mst_data, fp_data;
  logic        mst_req_sram, mst_req_other, mst_rwn, fp_req_sram, fp_req_other, fp_rwn;
  logic [1:0]  grant, fp_grant;
  logic        terr, fp_terr;

  int checks = 0;
  int failures = 0;

  always #5 clk6x = ~clk6x;

  nora_mst_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) dut (
    .clk6x(clk6x), .reset(reset),
    .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_req_sram_i(m0_sram),
    .m0_req_other_i(m0_other), .m0_rwn_i(m0_rwn), .m0_lock_i(m0_lock),
    .m0_datard_o(m0_datard), .m0_ack_o(m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_req_sram_i(m1_sram),
    .m1_req_other_i(m1_other), .m1_rwn_i(m1_rwn), .m1_lock_i(m1_lock),
    .m1_datard_o(m1_datard), .m1_ack_o(m1_ack),
    .mst_addr_o(mst_addr), .mst_data_o(mst_data), .mst_req_sram_o(mst_req_sram),
    .mst_req_other_o(mst_req_other), .mst_rwn_o(mst_rwn), .mst_datard_i(mst_datard),
    .mst_ack_i(mst_ack), .grant_o(grant), .timeout_err_o(terr), .err_clr_i(err_clr)
  );

  nora_mst_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b1)) dut_fp (
    .clk6x(clk6x), .reset(reset),
    .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_req_sram_i(m0_sram),
    .m0_req_other_i(m0_other), .m0_rwn_i(m0_rwn), .m0_lock_i(m0_lock),
    .m0_datard_o(fp_m0_datard), .m0_ack_o(fp_m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_req_sram_i(m1_sram),
    .m1_req_other_i(m1_other), .m1_rwn_i(m1_rwn), .m1_lock_i(m1_lock),
    .m1_datard_o(fp_m1_datard), .m1_ack_o(fp_m1_ack),
    .mst_addr_o(fp_addr), .mst_data_o(fp_data), .mst_req_sram_o(fp_req_sram),
    .mst_req_other_o(fp_req_other), .mst_rwn_o(fp_rwn), .mst_datard_i(mst_datard),
    .mst_ack_i(fp_ack), .grant_o(fp_grant), .timeout_err_o(fp_terr), .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk6x);
    #1;
  endtask

  task automatic ack_now(input logic [7:0] d);
    mst_ack    = 1'b1;
    mst_datard = d;
    step();
    mst_ack    = 1'b0;
  endtask

  task automatic do_reset();
    m0_sram = 1'b0; m0_other = 1'b0; m1_sram = 1'b0; m1_other = 1'b0;
    m0_lock = 1'b0; m1_lock = 1'b0; mst_ack = 1'b0; fp_ack = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_req_sram", {31'd0, mst_req_sram}, 32'd0);
    chk("rst_req_other", {31'd0, mst_req_other}, 32'd0);
    chk("rst_rwn", {31'd0, mst_rwn}, 32'd1);
    chk("rst_addr", {8'd0, mst_addr}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_datard", {16'd0, m1_datard, m0_datard}, 32'd0);
    chk("rst_err", {31'd0, terr}, 32'd0);
    reset = 1'b0;
    step();

    // Single read from m0
    m0_addr = 24'h012345; m0_rwn = 1'b1; m0_sram = 1'b1;
    step();
    chk("rd_req_rise", {31'd0, mst_req_sram}, 32'd1);
    chk("rd_addr", {8'd0, mst_addr}, 32'h012345);
    chk("rd_rwn", {31'd0, mst_rwn}, 32'd1);
    chk("rd_grant", {30'd0, grant}, 32'd1);
    step();
    step();
    chk("rd_no_early_ack", {31'd0, m0_ack}, 32'd0);
    ack_now(8'hA5);
    m0_sram = 1'b0;
    chk("rd_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_datard", {24'd0, m0_datard}, 32'hA5);
    chk("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rd_req_drop", {31'd0, mst_req_sram}, 32'd0);
    chk("rd_done_grant", {30'd0, grant}, 32'd1);
    step();
    chk("rd_ack_pulse", {31'd0, m0_ack}, 32'd0);
    chk("rd_idle_grant", {30'd0, grant}, 32'd0);
    chk("rd_datard_hold", {24'd0, m0_datard}, 32'hA5);

    // Round-robin contention: 4 accesses -> 0,1,0,1
    do_reset();
    m0_sram = 1'b1; m0_rwn = 1'b0; m0_addr = 24'h000100; m0_data = 8'h11;
    m1_other = 1'b1; m1_rwn = 1'b0; m1_addr = 24'h000200; m1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_grant", {30'd0, grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_req", {30'd0, mst_req_other, mst_req_sram}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", {24'd0, mst_data}, (i % 2 == 0) ? 32'h11 : 32'h22);
      ack_now(8'h40 + 8'(i));
      chk("rr_acks", {30'd0, m1_ack, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_done_req", {30'd0, mst_req_other, mst_req_sram}, 32'd0);
      step();
    end

    // Lock: m1 keeps ownership for 3 writes while m0 waits
    do_reset();
    m1_sram = 1'b1; m1_lock = 1'b1; m1_rwn = 1'b0;
    step();
    m0_sram = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("lk_grant_m1", {30'd0, grant}, 32'd2);
      if (i == 2) m1_lock = 1'b0;
      ack_now(8'h50);
      chk("lk_acks", {30'd0, m1_ack, m0_ack}, 32'd2);
      step();
    end
    step();
    chk("lk_release_grant", {30'd0, grant}, 32'd1);

    // Timeout with no downstream ack
    do_reset();
    m0_sram = 1'b1; m0_rwn = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_req_held", {31'd0, mst_req_sram}, 32'd1);
    chk("to_no_ack_yet", {31'd0, m0_ack}, 32'd0);
    step();
    m0_sram = 1'b0;
    chk("to_ack", {31'd0, m0_ack}, 32'd1);
    chk("to_datard", {24'd0, m0_datard}, 32'hFF);
    chk("to_err_set", {31'd0, terr}, 32'd1);
    step();
    chk("to_err_sticky", {31'd0, terr}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", {31'd0, terr}, 32'd0);

    // Ack in the last cycle before timeout: normal completion, no error
    m0_sram = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    ack_now(8'h3C);
    m0_sram = 1'b0;
    chk("to_edge_ack", {31'd0, m0_ack}, 32'd1);
    chk("to_edge_datard", {24'd0, m0_datard}, 32'h3C);
    chk("to_edge_no_err", {31'd0, terr}, 32'd0);
    step();

    // Reset mid-BUSY
    m1_sram = 1'b1; m1_addr = 24'hABCDEF; m1_rwn = 1'b0;
    step();
    chk("mr_busy_grant", {30'd0, grant}, 32'd2);
    step();
    reset = 1'b1;
    m0_sram = 1'b1;
    step();
    chk("mr_req", {31'd0, mst_req_sram}, 32'd0);
    chk("mr_grant", {30'd0, grant}, 32'd0);
    chk("mr_addr", {8'd0, mst_addr}, 32'd0);
    chk("mr_rwn", {31'd0, mst_rwn}, 32'd1);
    chk("mr_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    reset = 1'b0;
    step();
    chk("mr_first_grant", {30'd0, grant}, 32'd1);

    // Fixed priority instance: m1 waits until m0 goes idle
    do_reset();
    m0_sram = 1'b1; m1_sram = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fp_grant_m0", {30'd0, fp_grant}, 32'd1);
      fp_ack = 1'b1;
      step();
      fp_ack = 1'b0;
      if (i == 1) m0_sram = 1'b0;
      chk("fp_acks", {30'd0, fp_m1_ack, fp_m0_ack}, 32'd1);
      step();
    end
    step();
    chk("fp_grant_m1", {30'd0, fp_grant}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
